// File: rtl/xphy_train_defs_pkg.sv
// Shared definitions for the 10GBASE-R training responder: register indices,
// control-bit position and FSM state encoding.
package xphy_train_defs;

    localparam int         IDX_W            = 4;
    localparam logic [3:0] REG_CTRL         = 4'd0;
    localparam logic [3:0] REG_STATUS       = 4'd1;
    localparam int         CTRL_SOFTRST_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } train_state_t;

endpackage

// File: rtl/xphy_train_regfile.sv
// Register bank behind the training responder: control (self-clearing bit 15),
// live status passthrough on reg 1, and plain RW coefficient registers.
module xphy_train_regfile
    import xphy_train_defs::*;
#(
    parameter int C_NUM_REGS = 8
) (
    input  logic                    clk156,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [15:0]             wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    input  logic [15:0]             status_in,
    output logic [15:0]             rd_data,
    output logic [16*C_NUM_REGS-1:0] reg_out,
    output logic                    soft_reset_pulse
);

    logic [15:0] regs_r [C_NUM_REGS];

    // Register storage; reg 1 holds no state and stays at zero.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
            soft_reset_pulse <= 1'b0;
        end else begin
            soft_reset_pulse <= wr_en && (wr_idx == REG_CTRL) && wr_data[CTRL_SOFTRST_BIT];
            if (wr_en && (wr_idx == REG_CTRL)) begin
                regs_r[0] <= {1'b0, wr_data[CTRL_SOFTRST_BIT-1:0]};
            end
            for (int i = 2; i < C_NUM_REGS; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    regs_r[i] <= wr_data;
                end
            end
        end
    end

    // Read mux; the status slot returns the live input rather than storage.
    always_comb begin
        rd_data = 16'h0000;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            rd_data = (rd_idx == IDX_W'(i)) ? regs_r[i] : rd_data;
        end
        rd_data = (rd_idx == REG_STATUS) ? status_in : rd_data;
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_flat
        assign reg_out[16*g +: 16] = regs_r[g];
    end

endmodule

// File: rtl/xphy_training_responder.sv
// Responder side of the PHY training IPIF: accepts cs transactions, acks them
// after a fixed latency, and services a small register bank.
module xphy_training_responder
    import xphy_train_defs::*;
#(
    parameter logic [4:0]  C_MMD         = 5'h01,
    parameter logic [15:0] C_BASE_ADDR   = 16'h0000,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_ACK_LATENCY = 2,
    parameter logic [15:0] C_MISS_DATA   = 16'h0000
) (
    input  logic                     clk156,
    input  logic                     reset,
    input  logic                     training_enable,
    input  logic [20:0]              training_addr,
    input  logic                     training_rnw,
    input  logic [15:0]              training_wrdata,
    input  logic                     training_ipif_cs,
    output logic [15:0]              training_rddata,
    output logic                     training_rdack,
    output logic                     training_wrack,
    input  logic [15:0]              status_in,
    output logic [16*C_NUM_REGS-1:0] reg_out,
    output logic                     soft_reset_pulse,
    output logic [7:0]               miss_count
);

    train_state_t     state_r, state_s;
    logic [3:0]       cnt_r;
    logic [20:0]      addr_r;
    logic             rnw_r;
    logic [15:0]      wrdata_r;
    logic [15:0]      offset_s;
    logic             hit_s;
    logic             accept_s;
    logic             ack_edge_s;
    logic             wr_en_s;
    logic [15:0]      rf_rd_data_s;

    assign offset_s   = addr_r[15:0] - C_BASE_ADDR;
    assign hit_s      = (addr_r[20:16] == C_MMD) && (offset_s < 16'(C_NUM_REGS));
    assign accept_s   = (state_r == ST_IDLE) && training_ipif_cs && training_enable;
    assign ack_edge_s = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign wr_en_s    = (state_r == ST_ACK) && !rnw_r && hit_s;

    // Next-state logic; HOLD waits for cs to drop so a held cs never re-triggers.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = accept_s ? ST_WAIT : ST_IDLE;
            ST_WAIT: state_s = (cnt_r == 4'd0) ? ST_ACK : ST_WAIT;
            ST_ACK:  state_s = ST_HOLD;
            ST_HOLD: state_s = training_ipif_cs ? ST_HOLD : ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, latched request, latency counter and registered acks/read data.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 4'd0;
            addr_r          <= 21'd0;
            rnw_r           <= 1'b0;
            wrdata_r        <= 16'h0000;
            training_rdack  <= 1'b0;
            training_wrack  <= 1'b0;
            training_rddata <= 16'h0000;
            miss_count      <= 8'h00;
        end else begin
            state_r        <= state_s;
            training_rdack <= ack_edge_s && rnw_r;
            training_wrack <= ack_edge_s && !rnw_r;
            if (accept_s) begin
                addr_r   <= training_addr;
                rnw_r    <= training_rnw;
                wrdata_r <= training_wrdata;
                cnt_r    <= 4'(C_ACK_LATENCY - 1);
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (ack_edge_s && rnw_r) begin
                training_rddata <= hit_s ? rf_rd_data_s : C_MISS_DATA;
            end
            if ((state_r == ST_ACK) && !hit_s && (miss_count != 8'hFF)) begin
                miss_count <= miss_count + 8'd1;
            end
        end
    end

    xphy_train_regfile #(
        .C_NUM_REGS (C_NUM_REGS)
    ) u_regfile (
        .clk156           (clk156),
        .reset            (reset),
        .wr_en            (wr_en_s),
        .wr_idx           (offset_s[IDX_W-1:0]),
        .wr_data          (wrdata_r),
        .rd_idx           (offset_s[IDX_W-1:0]),
        .status_in        (status_in),
        .rd_data          (rf_rd_data_s),
        .reg_out          (reg_out),
        .soft_reset_pulse (soft_reset_pulse)
    );

endmodule

// File: tb/tb_xphy_training_responder.sv
// Directed plus randomized bench for the training responder, checked against an
// array-based register model.
module tb_xphy_training_responder;

    localparam int LAT = 2;

    logic         clk156 = 1'b0;
    logic         reset = 1'b1;
    logic         training_enable = 1'b1;
    logic [20:0]  training_addr = 21'd0;
    logic         training_rnw = 1'b0;
    logic [15:0]  training_wrdata = 16'h0000;
    logic         training_ipif_cs = 1'b0;
    logic [15:0]  status_in = 16'h0000;

    logic [15:0]  training_rddata, rddata1;
    logic         training_rdack, training_wrack, rdack1, wrack1;
    logic [127:0] reg_out, reg_out1;
    logic         soft_reset_pulse, soft1;
    logic [7:0]   miss_count, miss1;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] mdl [8];
    int miss_mdl = 0;
    logic drop_en = 1'b0;

    xphy_training_responder dut (
        .clk156(clk156), .reset(reset), .training_enable(training_enable),
        .training_addr(training_addr), .training_rnw(training_rnw),
        .training_wrdata(training_wrdata), .training_ipif_cs(training_ipif_cs),
        .training_rddata(training_rddata), .training_rdack(training_rdack),
        .training_wrack(training_wrack), .status_in(status_in), .reg_out(reg_out),
        .soft_reset_pulse(soft_reset_pulse), .miss_count(miss_count)
    );

    xphy_training_responder #(.C_ACK_LATENCY(1)) dut_l1 (
        .clk156(clk156), .reset(reset), .training_enable(training_enable),
        .training_addr(training_addr), .training_rnw(training_rnw),
        .training_wrdata(training_wrdata), .training_ipif_cs(training_ipif_cs),
        .training_rddata(rddata1), .training_rdack(rdack1),
        .training_wrack(wrack1), .status_in(status_in), .reg_out(reg_out1),
        .soft_reset_pulse(soft1), .miss_count(miss1)
    );

    always #5 clk156 = ~clk156;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] flat_model();
        logic [127:0] f;
        for (int i = 0; i < 8; i++) f[16*i +: 16] = mdl[i];
        return f;
    endfunction

    function automatic logic is_hit(input logic [20:0] a);
        return (a[20:16] == 5'h01) && (a[15:0] < 16'd8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        miss_mdl = 0;
    endtask

    // One initiator transaction: hold cs until ack, then check everything observed.
    task automatic txn(input logic [20:0] a, input logic r, input logic [15:0] d);
        logic [15:0]  rd, exp_rd;
        logic [127:0] ro;
        logic         wrong;
        int lat, lat1, nack, nack1, soft_at, exp_soft_at;
        exp_rd = 16'h0000;
        exp_soft_at = -1;
        if (!is_hit(a)) begin
            miss_mdl = (miss_mdl < 255) ? miss_mdl + 1 : 255;
        end else if (r) begin
            exp_rd = (a[15:0] == 16'd1) ? status_in : mdl[a[2:0]];
        end else if (a[15:0] == 16'd0) begin
            mdl[0] = {1'b0, d[14:0]};
            if (d[15]) exp_soft_at = LAT + 1;
        end else if (a[15:0] != 16'd1) begin
            mdl[a[2:0]] = d;
        end
        training_addr = a; training_rnw = r; training_wrdata = d; training_ipif_cs = 1'b1;
        @(posedge clk156);
        lat = -1; lat1 = -1; nack = 0; nack1 = 0; soft_at = -1; wrong = 1'b0;
        rd = 16'h0000; ro = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk156); #1;
            if (training_rdack || training_wrack) begin
                nack++;
                if (lat < 0) begin
                    lat = n; rd = training_rddata;
                    wrong = r ? training_wrack : training_rdack;
                    training_ipif_cs = 1'b0;
                end
            end
            if (rdack1 || wrack1) begin
                nack1++;
                if (lat1 < 0) lat1 = n;
            end
            if (soft_reset_pulse && soft_at < 0) soft_at = n;
            if (lat > 0 && n == lat + 1) ro = reg_out;
            if (n == 1) begin
                training_addr = a ^ 21'h1F0005; training_rnw = ~r; training_wrdata = ~d;
                if (drop_en) training_enable = 1'b0;
            end
        end
        training_ipif_cs = 1'b0; training_enable = 1'b1;
        @(posedge clk156); #1;
        chk("ack_latency", 128'(lat), 128'(LAT));
        chk("ack_count", 128'(nack), 128'd1);
        chk("ack_latency_l1", 128'(lat1), 128'd1);
        chk("ack_count_l1", 128'(nack1), 128'd1);
        chk("ack_kind", 128'(wrong), 128'd0);
        chk("soft_reset_at", 128'(soft_at), 128'(exp_soft_at));
        chk("miss_count", 128'(miss_count), 128'(miss_mdl));
        if (r) chk("rddata", 128'(rd), 128'(exp_rd));
        else   chk("reg_out", ro, flat_model());
    endtask

    initial begin
        int acks;
        model_reset();
        repeat (2) @(posedge clk156);
        #1;
        chk("rst_rdack", 128'(training_rdack), 128'd0);
        chk("rst_wrack", 128'(training_wrack), 128'd0);
        chk("rst_rddata", 128'(training_rddata), 128'd0);
        chk("rst_reg_out", reg_out, 128'd0);
        chk("rst_soft", 128'(soft_reset_pulse), 128'd0);
        chk("rst_miss", 128'(miss_count), 128'd0);
        reset = 1'b0;
        @(posedge clk156); #1;

        txn({5'h01, 16'd3}, 1'b1, 16'h0000);
        txn({5'h01, 16'd2}, 1'b0, 16'hBEEF);
        txn({5'h01, 16'd2}, 1'b1, 16'h0000);
        txn({5'h01, 16'd0}, 1'b0, 16'h8005);
        txn({5'h01, 16'd0}, 1'b1, 16'h0000);
        status_in = 16'h1234;
        txn({5'h01, 16'd1}, 1'b1, 16'h0000);
        txn({5'h01, 16'd1}, 1'b0, 16'hFFFF);
        status_in = 16'h5A5A;
        txn({5'h01, 16'd1}, 1'b1, 16'h0000);
        drop_en = 1'b1;
        txn({5'h01, 16'd4}, 1'b0, 16'hC0DE);
        drop_en = 1'b0;
        txn({5'h01, 16'd4}, 1'b1, 16'h0000);

        for (int i = 0; i < 80; i++) begin
            status_in = 16'($urandom);
            txn({(($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'h01), 16'($urandom_range(0, 10))},
                1'($urandom), 16'($urandom));
        end

        txn({5'h01, 16'd8}, 1'b1, 16'h0000);
        txn({5'h02, 16'd2}, 1'b0, 16'h1111);
        for (int i = 0; i < 300; i++) begin
            txn(($urandom_range(0, 1) == 0) ? {5'h01, 16'($urandom_range(8, 65535))}
                                            : {5'h1E, 16'($urandom_range(0, 7))},
                1'($urandom), 16'($urandom));
        end
        chk("miss_saturated", 128'(miss_count), 128'hFF);

        training_addr = {5'h01, 16'd3}; training_rnw = 1'b1; training_ipif_cs = 1'b1;
        acks = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk156); #1;
            if (training_rdack || training_wrack) acks++;
        end
        training_ipif_cs = 1'b0;
        chk("cs_held_one_ack", 128'(acks), 128'd1);
        @(posedge clk156); #1;

        training_enable = 1'b0; training_ipif_cs = 1'b1; acks = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk156); #1;
            if (training_rdack || training_wrack || rdack1 || wrack1) acks++;
        end
        training_ipif_cs = 1'b0; training_enable = 1'b1;
        chk("disabled_no_ack", 128'(acks), 128'd0);
        @(posedge clk156); #1;

        training_addr = {5'h01, 16'd2}; training_rnw = 1'b0;
        training_wrdata = 16'h1111; training_ipif_cs = 1'b1;
        @(posedge clk156); #1;
        reset = 1'b1; training_ipif_cs = 1'b0; acks = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk156); #1;
            if (n == 1) reset = 1'b0;
            if (training_rdack || training_wrack || rdack1 || wrack1) acks++;
        end
        model_reset();
        chk("abort_no_ack", 128'(acks), 128'd0);
        chk("abort_reg_out", reg_out, 128'd0);
        chk("abort_miss", 128'(miss_count), 128'd0);
        txn({5'h01, 16'd2}, 1'b1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
